// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and dmem.
//   m0_*/m1_* : per-master request, write enable, address, write data (to arbiter);
//               grant and read data (from arbiter).
//   mem_*     : dmem side; mem_we/mem_a/mem_wd driven by the arbiter, mem_rd by dmem.
// Modports:
//   slave  : arbiter view.
//   master : environment view (both requesters plus the memory).
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wd;
  logic          m0_gnt;
  logic [DW-1:0] m0_rd;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wd;
  logic          m1_gnt;
  logic [DW-1:0] m1_rd;

  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wd,
    input  m1_req, m1_we, m1_addr, m1_wd,
    input  mem_rd,
    output m0_gnt, m0_rd, m1_gnt, m1_rd,
    output mem_we, mem_a, mem_wd
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wd,
    output m1_req, m1_we, m1_addr, m1_wd,
    output mem_rd,
    input  m0_gnt, m0_rd, m1_gnt, m1_rd,
    input  mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data memory.
// Grants one master at a time (registered grants), breaks ties round-robin and
// forces a hand-over after MAX_BURST accesses when the other master is waiting.
// Ports:
//   clk   : clock, rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : dmem_arbiter_if.slave (master requests/grants/read data, dmem we/a/wd/rd).
module dmem_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input logic              clk,
  input logic              rst_n,
  dmem_arbiter_if.slave    bus
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MaxBeats = BW'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic [BW-1:0] beats_q, beats_d;
  logic [BW-1:0] beats_inc;
  logic          gnt0_q, gnt1_q;

  logic          we_sel;
  logic [AW-1:0] a_sel;
  logic [DW-1:0] wd_sel;

  assign beats_inc = (beats_q == MaxBeats) ? MaxBeats : beats_q + BW'(1);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    beats_d = beats_q;
    unique case (state_q)
      StIdle: begin
        if (bus.m0_req && (!bus.m1_req || !prio_q)) state_d = StOwn0;
        else if (bus.m1_req)                         state_d = StOwn1;
      end
      StOwn0: begin
        if (!bus.m0_req) begin
          state_d = bus.m1_req ? StOwn1 : StIdle;
          prio_d  = 1'b1;
        end else if (beats_inc == MaxBeats && bus.m1_req) begin
          // Preempted owner keeps tie priority so it is served first next time.
          state_d = StOwn1;
          prio_d  = 1'b0;
        end else begin
          beats_d = beats_inc;
        end
      end
      StOwn1: begin
        if (!bus.m1_req) begin
          state_d = bus.m0_req ? StOwn0 : StIdle;
          prio_d  = 1'b0;
        end else if (beats_inc == MaxBeats && bus.m0_req) begin
          state_d = StOwn0;
          prio_d  = 1'b1;
        end else begin
          beats_d = beats_inc;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) beats_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      beats_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      beats_q <= beats_d;
      gnt0_q  <= (state_d == StOwn0);
      gnt1_q  <= (state_d == StOwn1);
    end
  end

  // Memory side follows the owner combinationally so a read returns in the access cycle.
  always_comb begin
    we_sel = 1'b0;
    a_sel  = '0;
    wd_sel = '0;
    if (gnt0_q) begin
      we_sel = bus.m0_req & bus.m0_we;
      a_sel  = bus.m0_addr;
      wd_sel = bus.m0_wd;
    end else if (gnt1_q) begin
      we_sel = bus.m1_req & bus.m1_we;
      a_sel  = bus.m1_addr;
      wd_sel = bus.m1_wd;
    end
  end

  assign bus.mem_we = we_sel;
  assign bus.mem_a  = a_sel;
  assign bus.mem_wd = wd_sel;
  assign bus.m0_gnt = gnt0_q;
  assign bus.m1_gnt = gnt1_q;
  assign bus.m0_rd  = gnt0_q ? bus.mem_rd : '0;
  assign bus.m1_rd  = gnt1_q ? bus.mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by a random phase,
// each cycle compared against a transaction-level model of ownership and memory contents.
module tb_dmem_arbiter;
  localparam int unsigned MAXB = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .AW       (32),
    .DW       (32),
    .MAX_BURST(MAXB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // dmem: combinational read, write at rising edge.
  logic [31:0] ram [64] = '{default: '0};
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_a[7:2]] <= bus.mem_wd;
  assign bus.mem_rd = ram[bus.mem_a[7:2]];

  int n_pass  = 0;
  int n_total = 0;

  // Requester state: accesses still wanted, current access fields.
  int          left [2];
  logic [7:0]  addr [2];
  logic        we   [2];
  logic [31:0] wd   [2];
  bit          rnd_mode = 1'b0;

  // Reference model: owner (-1 none), accesses in current grant, tie winner.
  int          own  = -1;
  int          cnt  = 0;
  int          prio = 0;
  logic [31:0] ref_mem [64] = '{default: '0};

  logic [3:0]  tr [$];  // per cycle {acc1, acc0, gnt1, gnt0} seen on the DUT
  logic [31:0] last_a, last_rd0, last_rd1;
  logic        last_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic drive();
    bus.m0_req  = left[0] > 0;
    bus.m0_we   = we[0];
    bus.m0_addr = {24'h0, addr[0]};
    bus.m0_wd   = wd[0];
    bus.m1_req  = left[1] > 0;
    bus.m1_we   = we[1];
    bus.m1_addr = {24'h0, addr[1]};
    bus.m1_wd   = wd[1];
  endtask

  // One clock cycle: drive, check at negedge, advance model and requesters after the edge.
  task automatic step();
    bit rq [2];
    bit acc, ew;
    int n, nown, nprio, ncnt, o;
    if (rnd_mode) begin
      for (int m = 0; m < 2; m++) begin
        if (left[m] == 0 && $urandom_range(0, 2) == 0) begin
          left[m] = $urandom_range(1, 12);
          addr[m] = 8'($urandom);
          we[m]   = 1'($urandom);
          wd[m]   = $urandom;
        end
      end
    end
    drive();
    rq[0] = left[0] > 0;
    rq[1] = left[1] > 0;
    @(negedge clk);
    n   = own;
    acc = (own >= 0) ? rq[own] : 1'b0;
    ew  = acc ? we[n] : 1'b0;
    chk("gnt0", 32'(bus.m0_gnt), 32'(own == 0));
    chk("gnt1", 32'(bus.m1_gnt), 32'(own == 1));
    chk("mem_we", 32'(bus.mem_we), 32'(ew));
    if (own < 0) begin
      chk("idle_a", bus.mem_a, 32'h0);
      chk("idle_wd", bus.mem_wd, 32'h0);
    end
    if (acc) begin
      chk("mem_a", bus.mem_a, {24'h0, addr[n]});
      if (we[n]) chk("mem_wd", bus.mem_wd, wd[n]);
      else if (n == 0) chk("rd0", bus.m0_rd, ref_mem[addr[n][7:2]]);
      else chk("rd1", bus.m1_rd, ref_mem[addr[n][7:2]]);
    end
    if (own != 0) chk("rd0_zero", bus.m0_rd, 32'h0);
    if (own != 1) chk("rd1_zero", bus.m1_rd, 32'h0);
    tr.push_back({bus.m1_gnt & bus.m1_req, bus.m0_gnt & bus.m0_req, bus.m1_gnt, bus.m0_gnt});
    if ((bus.m0_gnt & bus.m0_req) | (bus.m1_gnt & bus.m1_req)) begin
      last_a   = bus.mem_a;
      last_we  = bus.mem_we;
      last_rd0 = bus.m0_rd;
      last_rd1 = bus.m1_rd;
    end
    // Ownership rules.
    nown = own; nprio = prio; ncnt = cnt;
    if (own < 0) begin
      if (rq[0] && rq[1]) nown = prio;
      else if (rq[0]) nown = 0;
      else if (rq[1]) nown = 1;
      ncnt = 0;
    end else begin
      o = 1 - own;
      if (!rq[own]) begin
        nown  = rq[o] ? o : -1;
        nprio = o;
        ncnt  = 0;
      end else begin
        ncnt = (cnt + 1 > int'(MAXB)) ? int'(MAXB) : cnt + 1;
        if (ncnt == int'(MAXB) && rq[o]) begin
          nown  = o;
          nprio = own;
          ncnt  = 0;
        end
      end
    end
    if (ew) ref_mem[addr[n][7:2]] = wd[n];
    @(posedge clk);
    #1;
    own = nown; prio = nprio; cnt = ncnt;
    if (acc) begin
      left[n]--;
      addr[n] += 8'd4;
      if (rnd_mode) begin
        we[n] = 1'($urandom);
        wd[n] = $urandom;
      end else begin
        wd[n]++;
      end
    end
  endtask

  task automatic run_idle();
    int k = 0;
    do begin
      step();
      k++;
    end while (!(left[0] == 0 && left[1] == 0 && own < 0) && k < 300);
    if (k >= 300) chk("idle_timeout", 32'(own), 32'hFFFF_FFFF);
  endtask

  initial begin
    int c, run, best, bad;
    left[0] = 3; addr[0] = 8'h80; we[0] = 1'b1; wd[0] = 32'h1000_0000;
    left[1] = 1; addr[1] = 8'hC0; we[1] = 1'b1; wd[1] = 32'h2000_0000;

    // Reset held with both requesting: nothing granted, no writes.
    for (int i = 0; i < 3; i++) begin
      drive();
      @(negedge clk);
      chk("rst_gnt0", 32'(bus.m0_gnt), 32'h0);
      chk("rst_gnt1", 32'(bus.m1_gnt), 32'h0);
      chk("rst_we", 32'(bus.mem_we), 32'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tr.delete();
    run_idle();
    chk("rst_idle_cycle", 32'(tr[0]), 32'h0);
    chk("rst_first_m0", 32'(tr[1]), 32'h5);

    // Tie from idle, m0 wins, zero-bubble hand-over on release.
    left[0] = 2; addr[0] = 8'h00; we[0] = 1'b0;
    left[1] = 1; addr[1] = 8'h04; we[1] = 1'b0;
    tr.delete();
    run_idle();
    chk("tie_first", 32'(tr[1]), 32'h5);
    chk("tie_release", 32'(tr[3]), 32'h1);
    chk("tie_handover", 32'(tr[4]), 32'hA);
    left[0] = 1; left[1] = 1;
    tr.delete();
    run_idle();
    chk("tie_again_m0", 32'(tr[1]), 32'h5);

    // Single write then read by m0.
    left[0] = 1; addr[0] = 8'h08; we[0] = 1'b1; wd[0] = 32'hDEAD_BEEF;
    tr.delete();
    run_idle();
    chk("wr_gnt", 32'(tr[1]), 32'h5);
    chk("wr_we", 32'(last_we), 32'h1);
    chk("wr_a", last_a, 32'h8);
    left[0] = 1; addr[0] = 8'h08; we[0] = 1'b0;
    run_idle();
    chk("rd_m0", last_rd0, 32'hDEAD_BEEF);
    chk("rd_m1_zero", last_rd1, 32'h0);

    // Forced hand-over: m1 arrives during m0's 3rd access.
    left[0] = 20; addr[0] = 8'h40; we[0] = 1'b1; wd[0] = 32'h3000_0000;
    tr.delete();
    step(); step(); step();
    left[1] = 1; addr[1] = 8'hF0; we[1] = 1'b1; wd[1] = 32'h55AA_0000;
    run_idle();
    c = 0;
    foreach (tr[i]) begin
      if (tr[i][1]) break;
      if (tr[i][2]) c++;
    end
    chk("burst_before_m1", 32'(c), 32'(MAXB));
    c = 0;
    foreach (tr[i]) if (tr[i][2]) c++;
    chk("burst_total_m0", 32'(c), 32'd20);
    bad = 0;
    for (int i = 0; i < 20; i++) if (ram[16 + i] !== 32'h3000_0000 + 32'(i)) bad++;
    chk("burst_ram_bad", 32'(bad), 32'h0);
    chk("burst_m1_ram", ram[60], 32'h55AA_0000);

    // Solo long burst: grant never drops.
    left[0] = 20; addr[0] = 8'h00; we[0] = 1'b1; wd[0] = 32'h4000_0000;
    tr.delete();
    run_idle();
    run = 0; best = 0;
    foreach (tr[i]) begin
      run  = tr[i][2] ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    chk("solo_run", 32'(best), 32'd20);
    bad = 0;
    for (int i = 0; i < 20; i++) if (ram[i] !== 32'h4000_0000 + 32'(i)) bad++;
    chk("solo_ram_bad", 32'(bad), 32'h0);

    // Async reset in the middle of an m1 write cycle.
    left[1] = 1; addr[1] = 8'h10; we[1] = 1'b1; wd[1] = 32'hCAFE_0001;
    step();
    drive();
    @(negedge clk);
    chk("mid_gnt1", 32'(bus.m1_gnt), 32'h1);
    chk("mid_we", 32'(bus.mem_we), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we", 32'(bus.mem_we), 32'h0);
    chk("async_gnt1", 32'(bus.m1_gnt), 32'h0);
    @(posedge clk);
    #1;
    chk("async_ram4", ram[4], 32'h4000_0004);
    own = -1; prio = 0; cnt = 0; left[1] = 0;
    rst_n = 1'b1;

    // Random phase.
    rnd_mode = 1'b1;
    for (int i = 0; i < 400; i++) step();
    rnd_mode = 1'b0;
    run_idle();
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("final_ram_bad", 32'(bad), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
